dmem_responder: RTL

- Data-memory responder on the single-cycle CPU's memory port: services loads combinationally and commits stores on the rising clock edge.
- Records every committed store in a trace FIFO, drained by a host/bench through a valid/ready handshake.
- Keeps store/drop statistics and a sticky bad-store flag.
- Sits beside the CPU inside top; address_to_mem, data_to_mem and write_enable come from the CPU.

---
 rtl/dmem_responder.sv | 91 +++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - CPU data-memory responder with store trace FIFO and statistics
module dmem_responder #(
    parameter int ADDR_WORDS = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [15:0] store_count,
    output logic [15:0] drop_count,
    output logic        addr_err
);
    localparam int AW = $clog2(ADDR_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    logic [31:0] mem [ADDR_WORDS];
    logic [31:0] fifo_addr [FIFO_DEPTH];
    logic [31:0] fifo_data [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    logic [29:0] index;
    logic        legal, store_ok, full, pop, push, drop;

    assign index    = address_to_mem[31:2];
    assign legal    = (address_to_mem[1:0] == 2'b00) && (index < 30'(ADDR_WORDS));
    assign store_ok = write_enable && legal;
    assign full     = (count == FULL_COUNT);
    assign pop      = trace_valid && trace_ready;
    // A full FIFO still accepts the new entry when the head leaves on the same edge.
    assign push     = store_ok && (!full || pop);
    assign drop     = store_ok && full && !pop;

    assign read_data   = legal ? mem[index[AW-1:0]] : 32'h0;
    assign trace_valid = (count != '0);
    assign trace_addr  = trace_valid ? fifo_addr[rd_ptr] : 32'h0;
    assign trace_data  = trace_valid ? fifo_data[rd_ptr] : 32'h0;

    // Storage arrays carry no reset: RAM contents survive reset, and FIFO slots are
    // masked by the occupancy counter.
    always_ff @(posedge clk) begin
        if (!reset && store_ok) begin
            mem[index[AW-1:0]] <= data_to_mem;
        end
        if (!reset && push) begin
            fifo_addr[wr_ptr] <= address_to_mem;
            fifo_data[wr_ptr] <= data_to_mem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            store_count <= '0;
            drop_count  <= '0;
            addr_err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (store_ok && store_count != 16'hFFFF) begin
                store_count <= store_count + 16'd1;
            end
            if (drop && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (write_enable && !legal) begin
                addr_err <= 1'b1;
            end
        end
    end
endmodule
